input_port_ctrl: RTL and testbench

//  Consumes the one-cycle press pulse from the button edge stage and serves the processor IN instruction.

---
 rtl/input_port_ctrl.sv | 99 +++++++++
 tb/tb_input_port_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - switch-bank input port serving the processor IN instruction
//
// Stalls the processor while an IN is pending. On the next button press pulse
// it captures the switch bank into in_data and releases the stall.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-high
//   in_req    processor is executing IN (level, held until stall drops)
//   btn_pulse one-cycle press pulse from the button edge stage
//   sw        switch bank, already synchronised
//   stall     freeze processor PC/pipeline (combinational)
//   in_data   captured, extended switch value (registered)
//   in_valid  one-cycle strobe marking new in_data for write-back (registered)
//   waiting   LED drive, high while waiting for a press (registered)
//   in_count  completed IN transfers, wraps 255->0 (registered)
module input_port_ctrl #(
  parameter int SW_W     = 8,
  parameter int DATA_W   = 32,
  parameter int SIGN_EXT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic              btn_pulse,
  input  logic [SW_W-1:0]   sw,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              waiting,
  output logic [7:0]        in_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

  // Fill every bit with the sign (or zero), then overlay the switches. This
  // form stays legal when DATA_W == SW_W, where a zero-width fill would not.
  logic [DATA_W-1:0] ext_sw;
  always_comb begin
    ext_sw = '0;
    if ((SIGN_EXT != 0) && sw[SW_W-1]) begin
      ext_sw = '1;
    end
    ext_sw[SW_W-1:0] = sw;
  end

  // Stall must rise in the very cycle in_req appears, so it cannot be registered.
  assign stall = ((state == IDLE) && in_req) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_data  <= '0;
      in_valid <= 1'b0;
      waiting  <= 1'b0;
      in_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          in_valid <= 1'b0;
          // A press arriving with in_req is not remembered; only a later one counts.
          if (in_req) begin
            state   <= WAIT;
            waiting <= 1'b1;
          end
        end
        WAIT: begin
          // A flush (in_req dropped) wins over a simultaneous press.
          if (!in_req) begin
            state   <= IDLE;
            waiting <= 1'b0;
          end else if (btn_pulse) begin
            state    <= DONE;
            in_data  <= ext_sw;
            in_valid <= 1'b1;
            in_count <= in_count + 8'd1;
            waiting  <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          in_valid <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_valid <= 1'b0;
          waiting  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - randomized and directed checks of input_port_ctrl against a reference model
module tb_input_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_req, btn_pulse;
  logic [7:0] sw;

  logic        stall_z, valid_z, wait_z;
  logic [31:0] data_z;
  logic [7:0]  cnt_z;
  logic        stall_s, valid_s, wait_s;
  logic [31:0] data_s;
  logic [7:0]  cnt_s;
  logic        stall_n, valid_n, wait_n;
  logic [7:0]  data_n;
  logic [7:0]  cnt_n;

  input_port_ctrl #(.SW_W(8), .DATA_W(32), .SIGN_EXT(0)) dut_z (
    .clk(clk), .rst(rst), .in_req(in_req), .btn_pulse(btn_pulse), .sw(sw),
    .stall(stall_z), .in_data(data_z), .in_valid(valid_z), .waiting(wait_z), .in_count(cnt_z));

  input_port_ctrl #(.SW_W(8), .DATA_W(32), .SIGN_EXT(1)) dut_s (
    .clk(clk), .rst(rst), .in_req(in_req), .btn_pulse(btn_pulse), .sw(sw),
    .stall(stall_s), .in_data(data_s), .in_valid(valid_s), .waiting(wait_s), .in_count(cnt_s));

  input_port_ctrl #(.SW_W(8), .DATA_W(8), .SIGN_EXT(1)) dut_n (
    .clk(clk), .rst(rst), .in_req(in_req), .btn_pulse(btn_pulse), .sw(sw),
    .stall(stall_n), .in_data(data_n), .in_valid(valid_n), .waiting(wait_n), .in_count(cnt_n));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: "pending" = a press is awaited, "just_done" = the
  // one-cycle window after a capture.
  bit          m_pend, m_done;
  logic [31:0] m_dz, m_ds;
  logic [7:0]  m_dn;
  int          m_cnt;
  int          hi_cnt;

  function automatic logic [31:0] zext(input logic [7:0] v);
    return {24'd0, v};
  endfunction

  function automatic logic [31:0] sext(input logic [7:0] v);
    return v[7] ? (32'hFFFFFF00 | {24'd0, v}) : {24'd0, v};
  endfunction

  task automatic model_clock();
    if (rst) begin
      m_pend = 0; m_done = 0; m_dz = 0; m_ds = 0; m_dn = 0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_pend) begin
      if (!in_req) begin
        m_pend = 0;
      end else if (btn_pulse) begin
        m_pend = 0;
        m_done = 1;
        m_dz   = zext(sw);
        m_ds   = sext(sw);
        m_dn   = sw;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end else if (in_req) begin
      m_pend = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic q, input logic b, input logic [7:0] s);
    logic exp_stall;
    @(negedge clk);
    rst = r; in_req = q; btn_pulse = b; sw = s;
    #1;
    exp_stall = m_pend || (in_req && !m_done);
    if (stall_z) hi_cnt++;
    check("stall_z", {31'd0, stall_z}, {31'd0, exp_stall});
    check("stall_s", {31'd0, stall_s}, {31'd0, exp_stall});
    check("stall_n", {31'd0, stall_n}, {31'd0, exp_stall});
    check("valid_z", {31'd0, valid_z}, {31'd0, m_done});
    check("valid_s", {31'd0, valid_s}, {31'd0, m_done});
    check("valid_n", {31'd0, valid_n}, {31'd0, m_done});
    check("wait_z", {31'd0, wait_z}, {31'd0, m_pend});
    check("wait_n", {31'd0, wait_n}, {31'd0, m_pend});
    check("data_z", data_z, m_dz);
    check("data_s", data_s, m_ds);
    check("data_n", {24'd0, data_n}, {24'd0, m_dn});
    check("cnt_z", {24'd0, cnt_z}, m_cnt);
    check("cnt_s", {24'd0, cnt_s}, m_cnt);
    check("cnt_n", {24'd0, cnt_n}, m_cnt);
    @(posedge clk);
    model_clock();
  endtask

  task automatic transfer(input logic [7:0] s);
    cycle(0, 1, 0, s);
    cycle(0, 1, 1, s);
    cycle(0, 0, 0, s);
  endtask

  initial begin
    rst = 1; in_req = 0; btn_pulse = 0; sw = 0;
    m_pend = 0; m_done = 0; m_dz = 0; m_ds = 0; m_dn = 0; m_cnt = 0; hi_cnt = 0;
    @(posedge clk);
    model_clock();

    // Reset state, then idle presses do nothing.
    cycle(1, 0, 0, 8'h00);
    #1;
    check("rst_stall", {31'd0, stall_z}, 32'd0);
    check("rst_cnt", {24'd0, cnt_z}, 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i % 2) == 0, 8'($urandom));
    #1;
    check("idle_cnt", {24'd0, cnt_z}, 32'd0);
    check("idle_valid", {31'd0, valid_z}, 32'd0);

    // Basic capture with press after five stalled cycles.
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'hA5);
    cycle(0, 1, 1, 8'hA5);
    cycle(0, 0, 0, 8'h3C);
    #1;
    check("t2_stall_cycles", hi_cnt, 32'd6);
    check("t2_data_z", data_z, 32'h000000A5);
    check("t2_data_s", data_s, 32'hFFFFFFA5);
    check("t2_cnt", {24'd0, cnt_z}, 32'd1);

    // Sign extension of 8'h80 and the equal-width case.
    transfer(8'h80);
    #1;
    check("t3_data_s", data_s, 32'hFFFFFF80);
    check("t3_data_z", data_z, 32'h00000080);
    check("t3_data_n", {24'd0, data_n}, 32'h00000080);

    // Press in the same cycle in_req rises is ignored.
    cycle(0, 1, 1, 8'h11);
    #1;
    check("t4_waiting", {31'd0, wait_z}, 32'd1);
    check("t4_no_valid", {31'd0, valid_z}, 32'd0);
    cycle(0, 1, 0, 8'h22);
    cycle(0, 1, 1, 8'h33);
    cycle(0, 0, 0, 8'h44);
    #1;
    check("t4_data", data_z, 32'h00000033);
    check("t4_cnt", {24'd0, cnt_z}, 32'd3);

    // Flush from WAIT, then reset while waiting with a press pending.
    cycle(0, 1, 0, 8'h55);
    cycle(0, 0, 1, 8'h55);
    cycle(0, 0, 0, 8'h55);
    #1;
    check("t5_flush_cnt", {24'd0, cnt_z}, 32'd3);
    check("t5_flush_wait", {31'd0, wait_z}, 32'd0);
    cycle(0, 1, 0, 8'h66);
    cycle(1, 1, 1, 8'h66);
    #1;
    check("t5_rst_data", data_z, 32'd0);
    check("t5_rst_cnt", {24'd0, cnt_z}, 32'd0);
    check("t5_rst_wait", {31'd0, wait_z}, 32'd0);
    check("t5_rst_valid", {31'd0, valid_z}, 32'd0);
    cycle(0, 0, 0, 8'h00);

    // 256 transfers wrap the counter; then a back-to-back IN re-stalls.
    for (int i = 0; i < 256; i++) transfer(8'($urandom));
    #1;
    check("t6_wrap", {24'd0, cnt_z}, 32'd0);
    cycle(0, 1, 0, 8'h77);
    cycle(0, 1, 1, 8'h77);
    cycle(0, 1, 0, 8'h88);
    cycle(0, 1, 0, 8'h99);
    check("t6_b2b_stall", {31'd0, stall_z}, 32'd1);
    cycle(0, 0, 0, 8'h00);

    // Random traffic.
    begin
      logic q;
      q = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(5) == 0) q = ~q;
        cycle(($urandom_range(199) == 0), q, ($urandom_range(3) == 0), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
